instruction_memory: RTL and testbench
=====================================

// Module: instruction_memory
// PURPOSE
//  Program store and responder for the processor's instruction-fetch port.
//  Returns a registered instruction byte for each read_address the core drives.
//  Has a byte-serial load port (valid/ready handshake) for writing a program
//  before execution. Sits beside the microprocessor at top level, on the same clock.
// PARAMETERS
//  ADDR_WIDTH  8      fetch/load address width; DEPTH = 2**ADDR_WIDTH words
//  DATA_WIDTH  8      instruction word width
//  NOP_WORD    8'h00  word returned when not running or when address >= program_length
// PORTS
//  clock           in   1           single system clock, rising edge
//  clear           in   1           synchronous, active-low reset (0 = reset)
//  load_start      in   1           pulse: begin new program load at address 0
//  load_valid      in   1           load_data valid this cycle
//  load_last       in   1           qualifies load_data as final program byte
//  load_data       in   DATA_WIDTH  program byte
//  load_ready      out  1           1 while in LOAD; byte accepted when valid&ready
//  run_enable      in   1           level: serve fetches while high
//  read_address    in   ADDR_WIDTH  fetch address from processor
//  instruction     out  DATA_WIDTH  fetched word, registered
//  instr_valid     out  1           instruction holds a served fetch
//  out_of_range    out  1           last fetch address >= program_length
//  program_length  out  ADDR_WIDTH+1 number of bytes stored (0..DEPTH)
//  load_full       out  1           last load ended by filling DEPTH words
// BEHAVIOUR
//  Reset (clear==0 at edge): state=IDLE, wr_ptr=0, program_length=0,
//   instruction=NOP_WORD, instr_valid=0, out_of_range=0, load_ready=0, load_full=0.
//   Memory array is not cleared; program_length=0 makes it logically empty.
//  States: IDLE, LOAD, RUN. Priority per cycle: clear > load_start > others.
//  IDLE: load_start -> LOAD. Else run_enable && program_length!=0 -> RUN.
//   Else stay. A load_valid arriving in the same cycle as load_start is ignored.
//  LOAD (entry sets wr_ptr=0, program_length=0, load_full=0):
//   load_ready=1. On valid&ready: mem[wr_ptr]<=load_data, wr_ptr++.
//   If load_last: program_length<=wr_ptr+1 and -> IDLE.
//   If wr_ptr==DEPTH-1 without load_last: program_length<=DEPTH, load_full<=1,
//   -> IDLE (no wrap). load_start in LOAD restarts at address 0.
//   instruction=NOP_WORD and instr_valid=0 throughout LOAD.
//  RUN: each cycle, registered (1-cycle latency):
//   instruction <= (read_address < program_length) ? mem[read_address] : NOP_WORD;
//   out_of_range <= !(read_address < program_length); instr_valid <= 1.
//   First valid instruction appears the cycle after entering RUN.
//   run_enable==0 -> IDLE: next cycle instruction=NOP_WORD, instr_valid=0.
//   load_start in RUN -> LOAD; takes priority over run_enable.
//  Compare uses ADDR_WIDTH+1 bits so program_length==DEPTH leaves all addresses in range.
//  Reset mid-LOAD aborts the load. The partial program is discarded (length 0).
//  Memory read is synchronous; infers block RAM, one write port and one read port.
// TESTING
//  Reset, then idle 5 cycles -> instruction=8'h00, instr_valid=0, load_ready=0, length=0.
//  Load 3 bytes 8'h41,8'h82,8'hC3 (last on third), run, addr 0,1,2 -> 41,82,C3 one cycle late.
//  After 3-byte load, read_address=5 in RUN -> instruction=8'h00, out_of_range=1.
//  Load 256 bytes without load_last -> load_full=1, length=256, addr 255 returns byte 255.
//  load_valid stalls (gaps) during load -> only valid&ready bytes are stored, in order.
//  clear=0 mid-load after 2 bytes; then run_enable=1 -> stays IDLE, length=0.

Source files
------------

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//
// Program store for the processor's instruction-fetch port. A program is
// written byte-serially through a valid/ready load port and then served back,
// one registered word per cycle, while run_enable is high.
//
// Ports
//   clock           in   1             system clock, rising edge
//   clear           in   1             synchronous active-low reset
//   load_start      in   1             pulse: start a new program load at address 0
//   load_valid      in   1             load_data is valid this cycle
//   load_last       in   1             load_data is the final program byte
//   load_data       in   DATA_WIDTH    program byte
//   load_ready      out  1             high while loading; byte taken on valid&ready
//   run_enable      in   1             level: serve fetches while high
//   read_address    in   ADDR_WIDTH    fetch address from the processor
//   instruction     out  DATA_WIDTH    fetched word (one-cycle latency)
//   instr_valid     out  1             instruction holds a served fetch
//   out_of_range    out  1             last fetch address >= program_length
//   program_length  out  ADDR_WIDTH+1  number of stored program bytes (0..DEPTH)
//   load_full       out  1             last load ended by filling every word
// -----------------------------------------------------------------------------
module instruction_memory #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  run_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic                  out_of_range,
    output logic [ADDR_WIDTH:0]   program_length,
    output logic                  load_full
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [LEN_W-1:0]      r_program_length;
    logic                  r_load_full;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic                  r_instr_valid;
    logic                  r_out_of_range;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_wr_en;
    logic w_in_range;
    logic w_ptr_at_end;

    // A byte is stored only when the load is not being restarted or reset in
    // the same cycle; load_start and clear both outrank the data handshake.
    assign w_wr_en      = clear && !load_start && (r_state == S_LOAD) && load_valid;

    // Compare in ADDR_WIDTH+1 bits so a full program (length == DEPTH) keeps
    // every address in range.
    assign w_in_range   = ({1'b0, read_address} < r_program_length);
    assign w_ptr_at_end = (r_wr_ptr == {ADDR_WIDTH{1'b1}});

    // NOTE: the array has no reset; clearing it would block RAM inference, and
    // program_length == 0 already makes stale contents unreachable.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= load_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state          <= S_IDLE;
            r_wr_ptr         <= '0;
            r_program_length <= '0;
            r_load_full      <= 1'b0;
            r_instruction    <= NOP_WORD;
            r_instr_valid    <= 1'b0;
            r_out_of_range   <= 1'b0;
        end else begin
            // Fetch outputs fall back to "nothing served" unless RUN overrides.
            r_instruction  <= NOP_WORD;
            r_instr_valid  <= 1'b0;
            r_out_of_range <= 1'b0;

            if (load_start) begin
                // New load from any state; discards the previous program.
                r_state          <= S_LOAD;
                r_wr_ptr         <= '0;
                r_program_length <= '0;
                r_load_full      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run_enable && (r_program_length != '0)) begin
                            r_state <= S_RUN;
                        end
                    end

                    S_LOAD: begin
                        if (load_valid) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (load_last) begin
                                r_program_length <= LEN_W'(r_wr_ptr) + LEN_W'(1);
                                r_state          <= S_IDLE;
                            end else if (w_ptr_at_end) begin
                                // Filled the array without a last marker: stop
                                // rather than wrap and overwrite address 0.
                                r_program_length <= LEN_W'(DEPTH);
                                r_load_full      <= 1'b1;
                                r_state          <= S_IDLE;
                            end
                        end
                    end

                    S_RUN: begin
                        if (run_enable) begin
                            r_instruction  <= w_in_range ? r_mem[read_address] : NOP_WORD;
                            r_instr_valid  <= 1'b1;
                            r_out_of_range <= !w_in_range;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign load_ready     = (r_state == S_LOAD);
    assign instruction    = r_instruction;
    assign instr_valid    = r_instr_valid;
    assign out_of_range   = r_out_of_range;
    assign program_length = r_program_length;
    assign load_full      = r_load_full;

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//
// Directed bench for instruction_memory: reset state, a short load with
// handshake gaps, fetch latency and out-of-range behaviour, a full-depth load,
// load restart from RUN, and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    logic        clock;
    logic        clear;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        run_enable;
    logic [7:0]  read_address;
    logic [7:0]  instruction;
    logic        instr_valid;
    logic        out_of_range;
    logic [8:0]  program_length;
    logic        load_full;

    int checks   = 0;
    int failures = 0;

    instruction_memory #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .NOP_WORD   (8'h00)
    ) dut (
        .clock          (clock),
        .clear          (clear),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_last      (load_last),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .run_enable     (run_enable),
        .read_address   (read_address),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .out_of_range   (out_of_range),
        .program_length (program_length),
        .load_full      (load_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear        = 1'b0;
        load_start   = 1'b0;
        load_valid   = 1'b0;
        load_last    = 1'b0;
        load_data    = 8'h00;
        run_enable   = 1'b0;
        read_address = 8'h00;

        // ---------------- reset, then idle ----------------
        step();
        step();
        clear = 1'b1;
        repeat (5) step();
        check("rst_instruction", 32'(instruction), 32'h00);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_load_ready",  32'(load_ready),  32'h0);
        check("rst_length",      32'(program_length), 32'h0);
        check("rst_oor",         32'(out_of_range), 32'h0);
        check("rst_full",        32'(load_full),    32'h0);

        // ---------------- 3-byte load with gaps ----------------
        // load_valid alongside load_start must be ignored (0xEE never stored).
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
        step();
        load_start = 1'b0; load_valid = 1'b0;
        check("load_ready_in_load", 32'(load_ready), 32'h1);
        check("load_len_cleared",   32'(program_length), 32'h0);

        load_valid = 1'b1; load_data = 8'h41; step();
        load_valid = 1'b0; load_data = 8'h99; step();           // gap
        check("load_no_fetch", 32'(instr_valid), 32'h0);
        load_valid = 1'b1; load_data = 8'h82; step();
        load_valid = 1'b0; load_data = 8'h77; step();           // gap
        load_valid = 1'b0; step();                               // gap
        load_valid = 1'b1; load_last = 1'b1; load_data = 8'hC3; step();
        load_valid = 1'b0; load_last = 1'b0;
        check("load3_length", 32'(program_length), 32'd3);
        check("load3_ready",  32'(load_ready), 32'h0);
        check("load3_full",   32'(load_full),  32'h0);

        // ---------------- run: one-cycle fetch latency ----------------
        run_enable = 1'b1; read_address = 8'd0;
        step();                                                  // IDLE -> RUN
        check("run_entry_valid", 32'(instr_valid), 32'h0);
        step();
        check("run_a0_instr", 32'(instruction), 32'h41);
        check("run_a0_valid", 32'(instr_valid), 32'h1);
        check("run_a0_oor",   32'(out_of_range), 32'h0);
        read_address = 8'd1; step();
        check("run_a1_instr", 32'(instruction), 32'h82);
        read_address = 8'd2; step();
        check("run_a2_instr", 32'(instruction), 32'hC3);
        check("run_a2_oor",   32'(out_of_range), 32'h0);
        read_address = 8'd5; step();
        check("run_a5_instr", 32'(instruction), 32'h00);
        check("run_a5_oor",   32'(out_of_range), 32'h1);
        read_address = 8'd3; step();                             // address == length
        check("run_a3_oor",   32'(out_of_range), 32'h1);
        check("run_a3_valid", 32'(instr_valid), 32'h1);

        run_enable = 1'b0; step();
        check("stop_instr", 32'(instruction), 32'h00);
        check("stop_valid", 32'(instr_valid), 32'h0);

        // ---------------- full-depth load, no load_last ----------------
        load_start = 1'b1; step();
        load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("full_ready_before_last", 32'(load_ready), 32'h1);
            load_valid = 1'b1;
            load_data  = 8'(i) ^ 8'hA5;
            step();
        end
        load_valid = 1'b0;
        check("full_flag",   32'(load_full), 32'h1);
        check("full_length", 32'(program_length), 32'd256);
        check("full_ready",  32'(load_ready), 32'h0);

        run_enable = 1'b1; read_address = 8'd255;
        step();                                                  // IDLE -> RUN
        step();
        check("full_a255_instr", 32'(instruction), 32'h5A);
        check("full_a255_oor",   32'(out_of_range), 32'h0);
        read_address = 8'd0; step();
        check("full_a0_instr", 32'(instruction), 32'hA5);
        read_address = 8'd128; step();
        check("full_a128_instr", 32'(instruction), 32'h25);

        // ---------------- load_start in RUN, then reset mid-load ----------------
        load_start = 1'b1; step();                               // run_enable still high
        load_start = 1'b0;
        check("restart_ready",  32'(load_ready), 32'h1);
        check("restart_length", 32'(program_length), 32'h0);
        check("restart_full",   32'(load_full), 32'h0);
        check("restart_valid",  32'(instr_valid), 32'h0);

        load_valid = 1'b1; load_data = 8'h11; step();
        load_data  = 8'h22; step();
        load_valid = 1'b0;
        clear = 1'b0; step();
        clear = 1'b1;
        check("abort_length", 32'(program_length), 32'h0);
        check("abort_ready",  32'(load_ready), 32'h0);
        repeat (3) step();                                       // run_enable still high
        check("abort_stay_idle_valid",  32'(instr_valid), 32'h0);
        check("abort_stay_idle_instr",  32'(instruction), 32'h00);
        check("abort_stay_idle_length", 32'(program_length), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
